rfid_reader_cmd_builder: RTL and testbench
==========================================

Name: rfid_reader_cmd_builder

Overview:
Upstream command assembler for the reader PIE transmitter. It takes a command code and field values and builds the EPC Gen2 bit string, computing CRC-5 or CRC-16 serially. It then drives the transmitter handshake: tx_go, send_trcal, tx_packet_length and tx_packet_data. After transmission it holds tx_go until the receive side reports completion.

Parameters:
MAX_BITS, 128, width of tx_packet_data; all commands fit within it.
LEN_W, 7, width of tx_packet_length.

Ports:
clk  in  1  system clock (10 MHz)
reset  in  1  asynchronous, active-low reset
cmd_go  in  1  start pulse; sampled only in IDLE
cmd_sel  in  3  0 QueryRep, 1 ACK, 2 Query, 3 QueryAdjust, 4 ReqRN, 5 NAK, 6-7 invalid
q_dr, q_trext, q_target  in  1 each  Query fields
q_m, q_sel, session  in  2 each  Query M/Sel; session for Query, QueryRep, QueryAdjust
q_q  in  4  Query Q value
updn  in  3  QueryAdjust UpDn field
rn16  in  16  handle/RN16 for ACK and ReqRN
tx_done  in  1  from transmitter; last bit sent
rx_done  in  1  from receive chain; reply handled or timed out
tx_go  out  1  transmitter start; held high through TX and RX
send_trcal  out  1  1 for Query only (preamble), else 0 (frame-sync)
tx_packet_length  out  7  number of valid bits
tx_packet_data  out  128  first-sent bit at index length-1; bits at index >= length are 0
busy  out  1  high whenever state != IDLE
cmd_done  out  1  one-cycle pulse on return to IDLE
cmd_error  out  1  one-cycle pulse on an invalid cmd_sel

Behaviour:
- Reset, asynchronous active-low: state IDLE. tx_go, send_trcal, busy, cmd_done and cmd_error are 0; tx_packet_length is 0; tx_packet_data is 0; CRC registers are cleared.
- Frame formats, MSB first, payload then CRC:
  - QueryRep: 00, session. 4 bits, no CRC.
  - ACK: 01, rn16. 18 bits, no CRC.
  - Query: 1000, DR, M, TRext, Sel, Session, Target, Q, then CRC-5. 17+5 = 22 bits.
  - QueryAdjust: 1001, session, updn. 9 bits, no CRC.
  - ReqRN: 11000001, rn16, then CRC-16. 24+16 = 40 bits.
  - NAK: 11000000. 8 bits, no CRC.
- CRC-5: polynomial x^5+x^3+1, preset 5'b01001, appended as is.
- CRC-16: CCITT polynomial 0x1021, preset 0xFFFF, appended ones-complemented.
- FSM states: IDLE, LOAD, CRC, GO, WAIT_TX, WAIT_RX.
  - IDLE -> LOAD on cmd_go with a valid cmd_sel. Payload, length and send_trcal are latched; input fields are ignored after this cycle.
  - Invalid cmd_sel: pulse cmd_error and stay in IDLE.
  - LOAD -> CRC for Query and ReqRN; otherwise LOAD -> GO.
  - CRC: one payload bit per clock, MSB first; 17 cycles for Query, 24 for ReqRN. The shift counter is sized for MAX_BITS. Then the CRC is appended and the FSM moves to GO.
  - GO: assert tx_go, move to WAIT_TX. Data, length and send_trcal are stable from one cycle before tx_go rises until tx_go falls.
  - WAIT_TX -> WAIT_RX on tx_done.
  - WAIT_RX: on rx_done, deassert tx_go, pulse cmd_done, return to IDLE.
- Latency, cmd_go to tx_go rising: 2 cycles for no-CRC commands; 2 + N cycles for CRC commands, where N is the payload bit count.
- rx_done arriving in WAIT_TX, simultaneous with or before tx_done: it is recorded. Exit to IDLE happens on the tx_done cycle, so tx_go never drops mid-transmission.
- cmd_go while busy is ignored; no queueing, no error.
- Reset mid-operation: immediate return to reset values. tx_go dropping returns the transmitter to idle after its current wait.

Decomposition:
- Shared package rfid_reader_pkg holds:
  - cmd_sel codes and per-command lengths.
  - Command prefixes (2'b00, 2'b01, 4'b1000, 4'b1001, 8'hC1, 8'hC0).
  - CRC polynomials and presets, and the CRC-5/CRC-16 residue constants.
- One sub-module, rfid_crc_serial: shared 5/16-bit serial CRC with clear/preset, bit_in, bit_valid and a width select. It is reused later by the reply checker.

Test Plan:
- QueryRep, session=2'b10 -> 2 cycles later tx_go=1, length=4, data[3:0]=4'b0010, send_trcal=0; tx_done then rx_done -> tx_go=0, single cmd_done pulse.
- ACK, rn16=16'hABCD -> length=18, data[17:0]=18'h1ABCD, send_trcal=0, all higher bits 0.
- Query with all fields 0 -> length=22, data[21:5]=17'h10000, send_trcal=1, tx_go 19 cycles after cmd_go. The CRC-5 of all 22 bits, preset 01001, gives residue 00000.
- ReqRN, rn16=16'h1234 -> length=40, data[39:16]=24'hC11234, tx_go 26 cycles after cmd_go. Bench CRC-16 over 40 bits gives residue 16'h1D0F.
- cmd_sel=7 -> cmd_error pulse, busy stays 0. A second cmd_go during WAIT_TX is ignored. rx_done before tx_done -> tx_go falls only after tx_done.
- reset asserted during CRC state -> all outputs at reset values on the same edge. A next QueryAdjust (session=1, updn=3'b110) -> length=9, data=9'b100101110.

Source files
------------

// File: rtl/rfid_reader_pkg.sv
// rtl/rfid_reader_pkg.sv - shared EPC Gen2 command codes, frame constants and CRC parameters
package rfid_reader_pkg;

    localparam logic [2:0] CMD_QUERYREP = 3'd0;
    localparam logic [2:0] CMD_ACK      = 3'd1;
    localparam logic [2:0] CMD_QUERY    = 3'd2;
    localparam logic [2:0] CMD_QUERYADJ = 3'd3;
    localparam logic [2:0] CMD_REQRN    = 3'd4;
    localparam logic [2:0] CMD_NAK      = 3'd5;

    // Full on-air lengths (payload + CRC) and payload-only lengths of CRC commands
    localparam int LEN_QUERYREP = 4;
    localparam int LEN_ACK      = 18;
    localparam int LEN_QUERY    = 22;
    localparam int LEN_QUERYADJ = 9;
    localparam int LEN_REQRN    = 40;
    localparam int LEN_NAK      = 8;
    localparam int PAY_QUERY    = 17;
    localparam int PAY_REQRN    = 24;

    localparam logic [1:0] PFX_QUERYREP = 2'b00;
    localparam logic [1:0] PFX_ACK      = 2'b01;
    localparam logic [3:0] PFX_QUERY    = 4'b1000;
    localparam logic [3:0] PFX_QUERYADJ = 4'b1001;
    localparam logic [7:0] PFX_REQRN    = 8'hC1;
    localparam logic [7:0] PFX_NAK      = 8'hC0;

    localparam logic [4:0]  CRC5_POLY     = 5'b01001;
    localparam logic [4:0]  CRC5_PRESET   = 5'b01001;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'b00000;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CRC,
        S_GO,
        S_WAIT_TX,
        S_WAIT_RX
    } state_e;

endpackage

// File: rtl/rfid_reader_cmd_builder_if.sv
// rtl/rfid_reader_cmd_builder_if.sv - command request and transmitter handshake bundle
interface rfid_reader_cmd_builder_if #(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = 7
);
    logic                cmd_go;
    logic [2:0]          cmd_sel;
    logic                q_dr;
    logic                q_trext;
    logic                q_target;
    logic [1:0]          q_m;
    logic [1:0]          q_sel;
    logic [1:0]          session;
    logic [3:0]          q_q;
    logic [2:0]          updn;
    logic [15:0]         rn16;
    logic                tx_done;
    logic                rx_done;
    logic                tx_go;
    logic                send_trcal;
    logic [LEN_W-1:0]    tx_packet_length;
    logic [MAX_BITS-1:0] tx_packet_data;
    logic                busy;
    logic                cmd_done;
    logic                cmd_error;

    modport master (
        output cmd_go, cmd_sel, q_dr, q_trext, q_target, q_m, q_sel, session, q_q, updn, rn16,
               tx_done, rx_done,
        input  tx_go, send_trcal, tx_packet_length, tx_packet_data, busy, cmd_done, cmd_error
    );

    modport slave (
        input  cmd_go, cmd_sel, q_dr, q_trext, q_target, q_m, q_sel, session, q_q, updn, rn16,
               tx_done, rx_done,
        output tx_go, send_trcal, tx_packet_length, tx_packet_data, busy, cmd_done, cmd_error
    );

endinterface

// File: rtl/rfid_crc_serial.sv
// rtl/rfid_crc_serial.sv - bit-serial CRC-5 / CRC-16 engine, MSB first
module rfid_crc_serial
    import rfid_reader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wide,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [15:0] crc_next
);

    logic [15:0] crc_q;
    logic        fb;

    // crc_next already includes bit_in so a caller can use the final value on the last bit
    always_comb begin
        fb       = 1'b0;
        crc_next = crc_q;
        if (wide) begin
            fb       = bit_in ^ crc_q[15];
            crc_next = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end else begin
            fb       = bit_in ^ crc_q[4];
            crc_next = {11'b0, {crc_q[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= wide ? CRC16_PRESET : {11'b0, CRC5_PRESET};
        end else if (bit_valid) begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/rfid_reader_cmd_builder.sv
// rtl/rfid_reader_cmd_builder.sv - builds Gen2 reader command frames and drives the PIE transmitter handshake
module rfid_reader_cmd_builder
    import rfid_reader_pkg::*;
#(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = 7
) (
    input  logic clk,
    input  logic reset,
    rfid_reader_cmd_builder_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BITS + 1);

    state_e              state_q, state_d;
    logic [MAX_BITS-1:0] data_q;
    logic [LEN_W-1:0]    len_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                trcal_q, crc_cmd_q, wide_q, rx_seen_q, done_q, err_q;

    logic [MAX_BITS-1:0] pay;
    logic [LEN_W-1:0]    len_sel;
    logic [CNT_W-1:0]    n_sel;
    logic                trcal_sel, crc_sel, wide_sel, sel_valid;

    always_comb begin
        pay       = '0;
        len_sel   = '0;
        n_sel     = '0;
        trcal_sel = 1'b0;
        crc_sel   = 1'b0;
        wide_sel  = 1'b0;
        sel_valid = 1'b1;
        case (bus.cmd_sel)
            CMD_QUERYREP: begin
                pay     = MAX_BITS'({PFX_QUERYREP, bus.session});
                len_sel = LEN_W'(LEN_QUERYREP);
            end
            CMD_ACK: begin
                pay     = MAX_BITS'({PFX_ACK, bus.rn16});
                len_sel = LEN_W'(LEN_ACK);
            end
            CMD_QUERY: begin
                pay       = MAX_BITS'({PFX_QUERY, bus.q_dr, bus.q_m, bus.q_trext, bus.q_sel,
                                       bus.session, bus.q_target, bus.q_q});
                len_sel   = LEN_W'(LEN_QUERY);
                n_sel     = CNT_W'(PAY_QUERY);
                trcal_sel = 1'b1;
                crc_sel   = 1'b1;
            end
            CMD_QUERYADJ: begin
                pay     = MAX_BITS'({PFX_QUERYADJ, bus.session, bus.updn});
                len_sel = LEN_W'(LEN_QUERYADJ);
            end
            CMD_REQRN: begin
                pay      = MAX_BITS'({PFX_REQRN, bus.rn16});
                len_sel  = LEN_W'(LEN_REQRN);
                n_sel    = CNT_W'(PAY_REQRN);
                crc_sel  = 1'b1;
                wide_sel = 1'b1;
            end
            CMD_NAK: begin
                pay     = MAX_BITS'(PFX_NAK);
                len_sel = LEN_W'(LEN_NAK);
            end
            default: sel_valid = 1'b0;
        endcase
    end

    logic latch, crc_clear, crc_step, finish, err_set, rx_set;

    always_comb begin
        state_d   = state_q;
        latch     = 1'b0;
        crc_clear = 1'b0;
        crc_step  = 1'b0;
        finish    = 1'b0;
        err_set   = 1'b0;
        rx_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_go) begin
                    if (sel_valid) begin
                        latch   = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                crc_clear = 1'b1;
                state_d   = crc_cmd_q ? S_CRC : S_GO;
            end
            S_CRC: begin
                crc_step = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_GO;
            end
            S_GO: state_d = S_WAIT_TX;
            S_WAIT_TX: begin
                // An early reply is remembered but never cuts a transmission short
                if (bus.tx_done) begin
                    if (rx_seen_q || bus.rx_done) begin
                        finish  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_RX;
                    end
                end else if (bus.rx_done) begin
                    rx_set = 1'b1;
                end
            end
            S_WAIT_RX: begin
                if (bus.rx_done) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [MAX_BITS-1:0] bit_mask, crc_append;
    logic [15:0]         crc_next, crc_inv;
    logic                crc_bit;

    assign bit_mask   = MAX_BITS'(1) << (cnt_q - CNT_W'(1));
    assign crc_bit    = |(data_q & bit_mask);
    assign crc_inv    = ~crc_next;
    assign crc_append = wide_q ? ((data_q << 16) | MAX_BITS'(crc_inv))
                               : ((data_q << 5)  | MAX_BITS'(crc_next[4:0]));

    rfid_crc_serial u_crc (
        .clk       (clk),
        .reset     (reset),
        .clear     (crc_clear),
        .wide      (wide_q),
        .bit_in    (crc_bit),
        .bit_valid (crc_step),
        .crc_next  (crc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            trcal_q   <= 1'b0;
            crc_cmd_q <= 1'b0;
            wide_q    <= 1'b0;
            rx_seen_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= finish;
            err_q  <= err_set;
            if (latch) begin
                data_q    <= pay;
                len_q     <= len_sel;
                cnt_q     <= n_sel;
                trcal_q   <= trcal_sel;
                crc_cmd_q <= crc_sel;
                wide_q    <= wide_sel;
            end
            if (crc_step) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) data_q <= crc_append;
            end
            if (rx_set) rx_seen_q <= 1'b1;
            else if (state_q == S_IDLE) rx_seen_q <= 1'b0;
        end
    end

    assign bus.tx_go            = (state_q == S_WAIT_TX) || (state_q == S_WAIT_RX);
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.send_trcal       = trcal_q;
    assign bus.tx_packet_length = len_q;
    assign bus.tx_packet_data   = data_q;
    assign bus.cmd_done         = done_q;
    assign bus.cmd_error        = err_q;

endmodule

// File: tb/tb_rfid_reader_cmd_builder.sv
// tb/tb_rfid_reader_cmd_builder.sv - self-checking bench for rfid_reader_cmd_builder
module tb_rfid_reader_cmd_builder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    bit          exp_bits[$];
    bit          exp_trcal;
    int          exp_npay;
    logic [127:0] exp_data;

    rfid_reader_cmd_builder_if bus ();

    rfid_reader_cmd_builder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #50 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
    endfunction

    // Polynomial long division of (preset*x^n + msg*x^w) by gen; result equals the serial CRC register
    function automatic logic [15:0] poly_rem(input bit msg[$], input int w, input logic [16:0] gen,
                                             input logic [15:0] preset);
        bit          d[$];
        logic [15:0] r;
        d = msg;
        for (int i = 0; i < w; i++) d.push_back(1'b0);
        for (int i = 0; i < w; i++) d[i] = d[i] ^ preset[w-1-i];
        for (int i = 0; i + w < d.size(); i++)
            if (d[i]) for (int j = 0; j <= w; j++) d[i+j] = d[i+j] ^ gen[w-j];
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = d[d.size()-w+i];
        return r;
    endfunction

    function automatic void model(input logic [2:0] sel);
        logic [15:0] c;
        exp_bits.delete();
        exp_trcal = 1'b0;
        case (sel)
            3'd0: begin push_bits(2'b00, 2); push_bits(32'(bus.session), 2); end
            3'd1: begin push_bits(2'b01, 2); push_bits(32'(bus.rn16), 16); end
            3'd2: begin
                push_bits(4'b1000, 4); push_bits(32'(bus.q_dr), 1); push_bits(32'(bus.q_m), 2);
                push_bits(32'(bus.q_trext), 1); push_bits(32'(bus.q_sel), 2);
                push_bits(32'(bus.session), 2); push_bits(32'(bus.q_target), 1);
                push_bits(32'(bus.q_q), 4);
                exp_trcal = 1'b1;
            end
            3'd3: begin push_bits(4'b1001, 4); push_bits(32'(bus.session), 2); push_bits(32'(bus.updn), 3); end
            3'd4: begin push_bits(8'hC1, 8); push_bits(32'(bus.rn16), 16); end
            default: push_bits(8'hC0, 8);
        endcase
        exp_npay = exp_bits.size();
        if (sel == 3'd2) begin
            c = poly_rem(exp_bits, 5, 17'h00029, 16'h0009);
            push_bits(32'(c[4:0]), 5);
        end else if (sel == 3'd4) begin
            c = poly_rem(exp_bits, 16, 17'h11021, 16'hFFFF);
            push_bits(32'(~c), 16);
        end
        exp_data = '0;
        for (int i = 0; i < exp_bits.size(); i++) exp_data[exp_bits.size()-1-i] = exp_bits[i];
    endfunction

    task automatic randomize_fields();
        bus.q_dr     = 1'($urandom_range(0, 1));
        bus.q_trext  = 1'($urandom_range(0, 1));
        bus.q_target = 1'($urandom_range(0, 1));
        bus.q_m      = 2'($urandom_range(0, 3));
        bus.q_sel    = 2'($urandom_range(0, 3));
        bus.session  = 2'($urandom_range(0, 3));
        bus.q_q      = 4'($urandom_range(0, 15));
        bus.updn     = 3'($urandom_range(0, 7));
        bus.rn16     = 16'($urandom);
    endtask

    task automatic run_cmd(input logic [2:0] sel, input int mode, input bit poke);
        int           lat;
        int           exp_lat;
        bit           is_crc;
        bit           fr[$];
        logic [127:0] pre_data;
        logic [6:0]   pre_len;
        model(sel);
        is_crc  = (sel == 3'd2) || (sel == 3'd4);
        exp_lat = is_crc ? exp_npay + 2 : 2;
        bus.cmd_sel = sel;
        bus.cmd_go  = 1'b1;
        @(negedge clk);
        bus.cmd_go = 1'b0;
        check("busy_after_go", 128'(bus.busy), 128'(1));
        randomize_fields();
        lat = 0;
        pre_data = bus.tx_packet_data;
        pre_len  = bus.tx_packet_length;
        while (bus.tx_go !== 1'b1 && lat < 100) begin
            pre_data = bus.tx_packet_data;
            pre_len  = bus.tx_packet_length;
            @(negedge clk);
            lat++;
        end
        check("tx_go_latency", 128'(lat), 128'(exp_lat));
        check("length", 128'(bus.tx_packet_length), 128'(exp_bits.size()));
        check("data", bus.tx_packet_data, exp_data);
        check("send_trcal", 128'(bus.send_trcal), 128'(exp_trcal));
        check("data_before_go", pre_data, exp_data);
        check("length_before_go", 128'(pre_len), 128'(exp_bits.size()));
        if (is_crc) begin
            for (int i = int'(bus.tx_packet_length) - 1; i >= 0; i--) fr.push_back(bus.tx_packet_data[i]);
            if (sel == 3'd2) check("crc5_residue", 128'(poly_rem(fr, 5, 17'h00029, 16'h0009)), 128'(0));
            else             check("crc16_residue", 128'(poly_rem(fr, 16, 17'h11021, 16'hFFFF)), 128'h1D0F);
        end
        if (poke) begin
            bus.cmd_sel = 3'($urandom_range(0, 5));
            bus.cmd_go  = 1'b1;
            @(negedge clk);
            bus.cmd_go = 1'b0;
            check("poke_busy", 128'(bus.busy), 128'(1));
            check("poke_tx_go", 128'(bus.tx_go), 128'(1));
            check("poke_data", bus.tx_packet_data, exp_data);
            check("poke_error", 128'(bus.cmd_error), 128'(0));
        end
        if (mode == 0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            check("tx_go_after_tx_done", 128'(bus.tx_go), 128'(1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("tx_go_wait_rx", 128'(bus.tx_go), 128'(1));
            bus.rx_done = 1'b1;
            @(negedge clk);
            bus.rx_done = 1'b0;
        end else if (mode == 1) begin
            bus.rx_done = 1'b1;
            @(negedge clk);
            bus.rx_done = 1'b0;
            check("tx_go_after_early_rx", 128'(bus.tx_go), 128'(1));
            repeat (2) @(negedge clk);
            check("tx_go_hold_early_rx", 128'(bus.tx_go), 128'(1));
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
        end else begin
            bus.tx_done = 1'b1;
            bus.rx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            bus.rx_done = 1'b0;
        end
        check("tx_go_end", 128'(bus.tx_go), 128'(0));
        check("cmd_done_pulse", 128'(bus.cmd_done), 128'(1));
        check("busy_end", 128'(bus.busy), 128'(0));
        @(negedge clk);
        check("cmd_done_single", 128'(bus.cmd_done), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_go"}, 128'(bus.tx_go), 128'(0));
        check({tag, "_busy"}, 128'(bus.busy), 128'(0));
        check({tag, "_trcal"}, 128'(bus.send_trcal), 128'(0));
        check({tag, "_length"}, 128'(bus.tx_packet_length), 128'(0));
        check({tag, "_data"}, bus.tx_packet_data, 128'(0));
        check({tag, "_done"}, 128'(bus.cmd_done), 128'(0));
        check({tag, "_error"}, 128'(bus.cmd_error), 128'(0));
    endtask

    task automatic zero_fields();
        bus.q_dr = 1'b0; bus.q_trext = 1'b0; bus.q_target = 1'b0;
        bus.q_m = 2'b00; bus.q_sel = 2'b00; bus.session = 2'b00;
        bus.q_q = 4'h0; bus.updn = 3'b000; bus.rn16 = 16'h0000;
    endtask

    initial begin
        bus.cmd_go = 1'b0; bus.cmd_sel = 3'd0; bus.tx_done = 1'b0; bus.rx_done = 1'b0;
        zero_fields();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        zero_fields(); bus.session = 2'b10;
        run_cmd(3'd0, 0, 1'b0);
        check("queryrep_literal", bus.tx_packet_data, 128'h2);

        zero_fields(); bus.rn16 = 16'hABCD;
        run_cmd(3'd1, 1, 1'b0);
        check("ack_literal", bus.tx_packet_data, 128'h1ABCD);

        zero_fields();
        run_cmd(3'd2, 2, 1'b0);
        check("query_payload_literal", 128'(bus.tx_packet_data[21:5]), 128'h10000);

        zero_fields(); bus.rn16 = 16'h1234;
        run_cmd(3'd4, 0, 1'b1);
        check("reqrn_payload_literal", 128'(bus.tx_packet_data[39:16]), 128'hC11234);

        for (int k = 6; k <= 7; k++) begin
            bus.cmd_sel = 3'(k);
            bus.cmd_go  = 1'b1;
            @(negedge clk);
            bus.cmd_go = 1'b0;
            check("invalid_error_pulse", 128'(bus.cmd_error), 128'(1));
            check("invalid_busy", 128'(bus.busy), 128'(0));
            @(negedge clk);
            check("invalid_error_single", 128'(bus.cmd_error), 128'(0));
            check("invalid_still_idle", 128'(bus.busy), 128'(0));
        end

        randomize_fields();
        bus.cmd_sel = 3'd2;
        bus.cmd_go  = 1'b1;
        @(negedge clk);
        bus.cmd_go = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_crc", 128'(bus.busy), 128'(1));
        #10 reset = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        zero_fields(); bus.session = 2'b01; bus.updn = 3'b110;
        run_cmd(3'd3, 0, 1'b0);
        check("queryadjust_literal", bus.tx_packet_data, 128'b100101110);

        run_cmd(3'd5, 2, 1'b0);
        check("nak_literal", bus.tx_packet_data, 128'hC0);

        for (int k = 0; k < 14; k++) begin
            randomize_fields();
            run_cmd(3'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
